// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, cache request issue, in-order tag
// tracking, stale-response dropping after redirects, and a small decode queue.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h1c00_0000,
    parameter int unsigned           FETCH_WIDTH  = 2,
    parameter int unsigned           Q_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [ADDR_WIDTH-1:0]       flush_pc,
    input  logic                        branch,
    input  logic [ADDR_WIDTH-1:0]       predict_pc,
    input  logic                        stall,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [ADDR_WIDTH-1:0]       req_pc,
    input  logic                        resp_valid,
    input  logic [32*FETCH_WIDTH-1:0]   resp_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_WIDTH-1:0]       out_pc,
    output logic [32*FETCH_WIDTH-1:0]   out_inst,
    output logic [FETCH_WIDTH-1:0]      out_mask,
    output logic [ADDR_WIDTH-1:0]       pc
);
    localparam int unsigned GROUP_BYTES = FETCH_WIDTH * 4;
    localparam int unsigned OFF_W       = $clog2(GROUP_BYTES);
    localparam int unsigned PTR_W       = $clog2(Q_DEPTH);
    localparam int unsigned CNT_W       = $clog2(Q_DEPTH + 1);
    localparam int unsigned DATA_W      = 32 * FETCH_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(GROUP_BYTES - 1);
    localparam logic [CNT_W:0]        DEPTH      = (CNT_W + 1)'(Q_DEPTH);

    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]       count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d, tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [ADDR_WIDTH-1:0]  q_pc_q [Q_DEPTH];
    logic [ADDR_WIDTH-1:0]  q_pc_d [Q_DEPTH];
    logic [DATA_W-1:0]      q_inst_q [Q_DEPTH];
    logic [DATA_W-1:0]      q_inst_d [Q_DEPTH];
    logic [FETCH_WIDTH-1:0] q_mask_q [Q_DEPTH];
    logic [FETCH_WIDTH-1:0] q_mask_d [Q_DEPTH];
    logic [ADDR_WIDTH-1:0]  tag_pc_q [Q_DEPTH];
    logic [ADDR_WIDTH-1:0]  tag_pc_d [Q_DEPTH];
    logic [FETCH_WIDTH-1:0] tag_mask_q [Q_DEPTH];
    logic [FETCH_WIDTH-1:0] tag_mask_d [Q_DEPTH];

    logic                   redirect, fire, deq, resp_take, resp_drop;
    logic [OFF_W-1:0]       lane;
    logic [FETCH_WIDTH-1:0] new_mask;
    logic [CNT_W:0]         occupancy;

    assign occupancy = {1'b0, inflight_q} + {1'b0, count_q};
    assign redirect  = flush || branch;
    assign req_valid = rst && !stall && !redirect && (occupancy < DEPTH);
    assign req_pc    = pc_q & ALIGN_MASK;
    assign pc        = pc_q;
    assign fire      = req_valid && req_ready;
    assign out_valid = (count_q != '0);
    assign out_pc    = q_pc_q[head_q];
    assign out_inst  = q_inst_q[head_q];
    assign out_mask  = q_mask_q[head_q];
    assign deq       = out_valid && out_ready;
    assign resp_drop = resp_valid && (drop_q != '0);
    assign resp_take = resp_valid && (drop_q == '0) && (inflight_q != '0);
    assign lane      = pc_q[OFF_W-1:0] >> 2;

    always_comb begin
        new_mask = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            new_mask[i] = (OFF_W'(i) >= lane);
        end
    end

    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        head_d     = head_q;
        tail_d     = tail_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        q_pc_d     = q_pc_q;
        q_inst_d   = q_inst_q;
        q_mask_d   = q_mask_q;
        tag_pc_d   = tag_pc_q;
        tag_mask_d = tag_mask_q;

        if (flush) begin
            pc_d = flush_pc;
        end else if (branch) begin
            pc_d = predict_pc;
        end else if (fire) begin
            pc_d = req_pc + ADDR_WIDTH'(GROUP_BYTES);
        end

        if (redirect) begin
            // Everything still outstanding after this cycle's response becomes stale.
            drop_d     = drop_q - CNT_W'(resp_drop) + inflight_q - CNT_W'(resp_take);
            inflight_d = '0;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
        end else begin
            if (resp_drop) begin
                drop_d = drop_q - 1'b1;
            end
            if (fire) begin
                tag_pc_d[tag_wr_q]   = pc_q;
                tag_mask_d[tag_wr_q] = new_mask;
                tag_wr_d             = tag_wr_q + 1'b1;
            end
            if (resp_take) begin
                q_pc_d[tail_q]   = tag_pc_q[tag_rd_q];
                q_mask_d[tail_q] = tag_mask_q[tag_rd_q];
                q_inst_d[tail_q] = resp_data;
                tail_d           = tail_q + 1'b1;
                tag_rd_d         = tag_rd_q + 1'b1;
            end
            if (deq) begin
                head_d = head_q + 1'b1;
            end
            inflight_d = inflight_q + CNT_W'(fire) - CNT_W'(resp_take);
            count_d    = count_q + CNT_W'(resp_take) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_VECTOR;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            for (int unsigned i = 0; i < Q_DEPTH; i++) begin
                q_pc_q[i]     <= '0;
                q_inst_q[i]   <= '0;
                q_mask_q[i]   <= '0;
                tag_pc_q[i]   <= '0;
                tag_mask_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            q_pc_q     <= q_pc_d;
            q_inst_q   <= q_inst_d;
            q_mask_q   <= q_mask_d;
            tag_pc_q   <= tag_pc_d;
            tag_mask_q <= tag_mask_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order cache model plus an epoch-based reference of the
// fetch stream, driven by directed scenarios followed by a randomized phase.
module tb_fetch_unit;
    localparam int unsigned AW = 32;
    localparam int unsigned FW = 2;
    localparam int unsigned QD = 4;
    localparam logic [31:0] RV = 32'h1c00_0000;

    logic          clk = 1'b0;
    logic          rst, flush, branch, stall, req_ready, resp_valid, out_ready;
    logic [31:0]   flush_pc, predict_pc, req_pc, out_pc, pc;
    logic          req_valid, out_valid;
    logic [63:0]   resp_data, out_inst;
    logic [FW-1:0] out_mask;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_WIDTH(AW), .RESET_VECTOR(RV), .FETCH_WIDTH(FW), .Q_DEPTH(QD)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc), .branch(branch),
        .predict_pc(predict_pc), .stall(stall), .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .resp_valid(resp_valid), .resp_data(resp_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_mask(out_mask), .pc(pc)
    );

    typedef struct {
        logic [31:0]   pc;
        logic [FW-1:0] mask;
        logic [63:0]   data;
        int unsigned   epoch;
        int unsigned   due;
    } grp_t;

    grp_t          cache_q[$];
    grp_t          exp_q[$];
    logic [31:0]   mpc;
    int unsigned   epoch, live, cyc, lat_lo, lat_hi, resp_cnt;
    int unsigned   n_chk, n_pass;
    logic [31:0]   obs_req[$];
    logic [31:0]   obs_deq_pc[$];
    logic [FW-1:0] obs_deq_mask[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [FW-1:0] lane_mask(input logic [31:0] p);
        int unsigned first = (p / 4) % FW;
        logic [FW-1:0] m;
        for (int unsigned i = 0; i < FW; i++) m[i] = (i >= first);
        return m;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        return (i < obs_req.size()) ? obs_req[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic logic [31:0] dpc_at(input int i);
        return (i < obs_deq_pc.size()) ? obs_deq_pc[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic logic [FW-1:0] dmask_at(input int i);
        return (i < obs_deq_mask.size()) ? obs_deq_mask[i] : 'x;
    endfunction

    task automatic clear_obs();
        obs_req.delete();
        obs_deq_pc.delete();
        obs_deq_mask.delete();
    endtask

    // One clock cycle: present cache response, check outputs, advance the model.
    task automatic tick();
        grp_t g;
        logic exp_rv, fire, deq;
        resp_valid = 1'b0;
        resp_data  = {$urandom, $urandom};
        if (cache_q.size() != 0 && cache_q[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = cache_q[0].data;
        end
        #1;
        exp_rv = !stall && !flush && !branch && (live + exp_q.size() < QD);
        chk("req_valid", 64'(req_valid), 64'(exp_rv));
        chk("req_pc", 64'(req_pc), 64'(mpc & ~32'(FW * 4 - 1)));
        chk("pc", 64'(pc), 64'(mpc));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
            chk("out_inst", out_inst, exp_q[0].data);
            chk("out_mask", 64'(out_mask), 64'(exp_q[0].mask));
        end
        if (req_valid === 1'b1 && req_ready) obs_req.push_back(req_pc);
        if (out_valid === 1'b1 && out_ready) begin
            obs_deq_pc.push_back(out_pc);
            obs_deq_mask.push_back(out_mask);
        end
        if (resp_valid) resp_cnt++;

        fire = exp_rv && req_ready;
        deq  = (exp_q.size() != 0) && out_ready;
        if (deq) void'(exp_q.pop_front());
        if (resp_valid) begin
            g = cache_q.pop_front();
            if (g.epoch == epoch) begin
                live--;
                exp_q.push_back(g);
            end
        end
        if (fire) begin
            g.pc    = mpc;
            g.mask  = lane_mask(mpc);
            g.data  = {$urandom, $urandom};
            g.epoch = epoch;
            g.due   = cyc + $urandom_range(lat_hi, lat_lo);
            cache_q.push_back(g);
            live++;
        end
        if (flush || branch) begin
            epoch++;
            exp_q.delete();
            live = 0;
        end
        if (flush)       mpc = flush_pc;
        else if (branch) mpc = predict_pc;
        else if (fire)   mpc = (mpc & ~32'(FW * 4 - 1)) + 32'(FW * 4);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset(input int unsigned hold);
        #2 rst = 1'b0;
        resp_valid = 1'b0;
        #1;
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_pc", 64'(pc), 64'(RV));
        mpc = RV;
        cache_q.delete();
        exp_q.delete();
        live = 0;
        epoch++;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_req_valid", 64'(req_valid), 64'd0);
        chk("rst_hold_pc", 64'(pc), 64'(RV));
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; branch = 1'b0; stall = 1'b0;
        req_ready = 1'b0; out_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
        flush_pc = '0; predict_pc = '0;
        mpc = RV; epoch = 0; live = 0; cyc = 0; lat_lo = 1; lat_hi = 1;
        n_chk = 0; n_pass = 0; resp_cnt = 0;

        apply_reset(2);

        // streaming at full rate
        req_ready = 1'b1; out_ready = 1'b1;
        clear_obs();
        repeat (8) tick();
        chk("stream_req0", 64'(req_at(0)), 64'h1c00_0000);
        chk("stream_req1", 64'(req_at(1)), 64'h1c00_0008);
        chk("stream_req2", 64'(req_at(2)), 64'h1c00_0010);
        chk("stream_out0_pc", 64'(dpc_at(0)), 64'h1c00_0000);
        for (int i = 0; i < 3; i++) chk("stream_mask", 64'(dmask_at(i)), 64'd3);

        // unaligned branch target
        branch = 1'b1; predict_pc = 32'h1c00_0104;
        tick();
        branch = 1'b0;
        clear_obs();
        repeat (6) tick();
        chk("br_req0", 64'(req_at(0)), 64'h1c00_0100);
        chk("br_req1", 64'(req_at(1)), 64'h1c00_0108);
        chk("br_out0_pc", 64'(dpc_at(0)), 64'h1c00_0104);
        chk("br_out0_mask", 64'(dmask_at(0)), 64'd2);
        chk("br_out1_pc", 64'(dpc_at(1)), 64'h1c00_0108);
        chk("br_out1_mask", 64'(dmask_at(1)), 64'd3);

        // full queue with decode blocked
        flush = 1'b1; flush_pc = 32'h1c00_0040;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        clear_obs();
        repeat (8) tick();
        chk("full_accepted", 64'(obs_req.size()), 64'd4);
        chk("full_req_valid_low", 64'(req_valid), 64'd0);
        out_ready = 1'b1;
        clear_obs();
        tick();
        out_ready = 1'b0;
        repeat (5) tick();
        chk("full_pop_count", 64'(obs_deq_pc.size()), 64'd1);
        chk("full_refill_one", 64'(obs_req.size()), 64'd1);

        // flush with two requests in flight
        out_ready = 1'b1; req_ready = 1'b0;
        flush = 1'b1; flush_pc = 32'h1c00_0180;
        tick();
        flush = 1'b0;
        repeat (8) tick();
        lat_lo = 4; lat_hi = 4; req_ready = 1'b1;
        tick();
        tick();
        req_ready = 1'b0;
        flush = 1'b1; flush_pc = 32'h1c00_0200;
        tick();
        flush = 1'b0; req_ready = 1'b1; resp_cnt = 0;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
        chk("flush_out_valid", 64'(out_valid), 64'd1);
        chk("flush_first_pc", 64'(out_pc), 64'h1c00_0200);
        chk("flush_resps_seen", 64'(resp_cnt), 64'd3);

        // flush and branch together
        lat_lo = 1; lat_hi = 1;
        flush = 1'b1; flush_pc = 32'h1c00_0300;
        branch = 1'b1; predict_pc = 32'h1c00_0400;
        tick();
        flush = 1'b0; branch = 1'b0;
        chk("fb_pc", 64'(pc), 64'h1c00_0300);
        clear_obs();
        repeat (3) tick();
        chk("fb_req0", 64'(req_at(0)), 64'h1c00_0300);

        // address wrap
        flush = 1'b1; flush_pc = 32'hffff_fffc;
        tick();
        flush = 1'b0;
        clear_obs();
        repeat (4) tick();
        chk("wrap_req0", 64'(req_at(0)), 64'hffff_fff8);
        chk("wrap_req1", 64'(req_at(1)), 64'h0000_0000);
        chk("wrap_out0_mask", 64'(dmask_at(0)), 64'd2);

        // stall while the queue drains
        flush = 1'b1; flush_pc = 32'h1c00_0500;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        repeat (8) tick();
        stall = 1'b1; out_ready = 1'b1;
        clear_obs();
        repeat (5) tick();
        chk("stall_no_req", 64'(obs_req.size()), 64'd0);
        chk("stall_drained", 64'(obs_deq_pc.size()), 64'd4);
        chk("stall_pc_hold", 64'(pc), 64'h1c00_0520);
        stall = 1'b0;

        // randomized traffic
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 400; i++) begin
            stall      = ($urandom % 8) == 0;
            req_ready  = ($urandom % 4) != 0;
            out_ready  = ($urandom % 3) != 0;
            flush      = ($urandom % 25) == 0;
            branch     = ($urandom % 20) == 0;
            flush_pc   = $urandom;
            predict_pc = $urandom;
            tick();
        end
        flush = 1'b0; branch = 1'b0; stall = 1'b0;

        // reset in the middle of traffic
        req_ready = 1'b1; out_ready = 1'b0;
        repeat (3) tick();
        apply_reset(3);
        lat_lo = 1; lat_hi = 1; out_ready = 1'b1;
        clear_obs();
        repeat (2) tick();
        chk("post_rst_req0", 64'(req_at(0)), 64'(RV));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
